stream_reverse_unit: RTL and testbench
======================================

// Module: stream_reverse_unit
// PURPOSE
//   Streaming reversal engine: per-word bit reversal, per-word element (lane) reversal,
//   or whole-frame word-order reversal through an internal LIFO. Valid/ready in and out,
//   frames delimited by *_last. Sits between datapath stages needing endian/bit-order fixups.
// PARAMETERS
//   DATA_W    32  word width; must be a multiple of ELEM_W
//   ELEM_W    8   element width for element-reverse mode
//   FRAME_MAX 16  LIFO depth = max words per frame in frame-reverse mode (>=2)
// PORTS
//   clk      in   1       clock, all logic on rising edge
//   rst_n    in   1       asynchronous active-low reset
//   mode     in   2       00 pass, 01 bit-rev, 10 elem-rev, 11 frame-rev
//   s_valid  in   1       input word valid
//   s_ready  out  1       input accept
//   s_data   in   DATA_W  input word
//   s_last   in   1       last word of input frame
//   m_valid  out  1       output word valid
//   m_ready  in   1       output accept
//   m_data   out  DATA_W  output word
//   m_last   out  1       last word of output frame
//   busy     out  1       frame in progress (state != IDLE)
//   ovf_err  out  1       sticky: frame exceeded FRAME_MAX in mode 11
//   clr_err  in   1       synchronous clear of ovf_err
// BEHAVIOUR
// - Reset: state IDLE, m_valid/m_data/m_last/busy/ovf_err=0, LIFO count=0; s_ready=0 while rst_n low.
// - Beat = valid & ready same cycle. mode sampled on first beat of a frame (IDLE), held until
//   frame ends; mode changes mid-frame ignored.
// - States: IDLE, STREAM (modes 00/01/10), FILL, DRAIN (mode 11).
// - STREAM path: single output register, latency 1 (word accepted cycle N -> m_valid cycle N+1).
//   s_ready = !m_valid | m_ready (full throughput, no bubble under continuous ready).
//   00: m_data=s_data; 01: m_data[i]=s_data[DATA_W-1-i];
//   10: element k of m_data = element (DATA_W/ELEM_W-1-k) of s_data; bit order in element kept.
//   m_last=s_last of same word. Beat with s_last -> IDLE after accept (next frame may start the
//   following cycle; back-to-back frames allowed, mode re-sampled).
// - FILL: s_ready=1, m_valid=0; push each word, cnt++. Exit to DRAIN when s_last accepted or
//   cnt reaches FRAME_MAX (the FRAME_MAX-th push without s_last sets ovf_err; later words start
//   a new frame).
// - DRAIN: s_ready=0; first m_valid cycle after last push; pops newest-first, m_data unmodified;
//   m_last=1 on final (oldest) word; after that beat -> IDLE. m_valid/m_data held stable while
//   m_ready=0. Single-word frame: one output with m_last=1.
// - m_valid never drops without a beat; m_data/m_last stable while m_valid & !m_ready.
// - ovf_err: set has priority over clr_err in the same cycle.
// - Async reset mid-frame: all state and LIFO discarded immediately, outputs to reset values.
// - busy=1 in STREAM/FILL/DRAIN, including while last output word awaits m_ready.
// TESTING (DATA_W=32, ELEM_W=8, FRAME_MAX=4)
// - mode 01, s_data=32'h0000_0001,last -> next cycle m_data=32'h8000_0000, m_last=1, busy then 0.
// - mode 10, stream 32'h1122_3344,32'hA1B2_C3D4(last), m_ready=1 -> 32'h4433_2211,32'hD4C3_B2A1,
//   one word/cycle, m_last on second.
// - mode 11, A,B,C(last) -> s_ready low after C; outputs C,B,A, m_last only with A; random
//   m_ready stalls keep m_data stable.
// - mode 11, 5 words no last -> first 4 reversed (m_last on word 1), ovf_err=1; word 5 starts new
//   frame; clr_err pulse -> ovf_err=0.
// - mode 01 frame then mode 11 frame back-to-back, mode toggled mid-frame -> each frame uses mode
//   sampled at its first beat.
// - rst_n low during DRAIN after 2 of 3 words -> m_valid=0, busy=0 at once; new frame reverses
//   correctly.

Source files
------------

// File: rtl/stream_reverse_unit.sv
// Streaming reversal engine: per-word bit reversal, per-word lane reversal, or
// whole-frame word-order reversal through a LIFO, with valid/ready on both sides.
module stream_reverse_unit #(
  parameter int DATA_W    = 32,
  parameter int ELEM_W    = 8,
  parameter int FRAME_MAX = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              ovf_err,
  input  logic              clr_err
);

  // Handshake: a word moves on a side only in a cycle where valid and ready are
  // both high; m_valid, once raised, holds with stable m_data/m_last until taken.

  localparam int N_ELEM = DATA_W / ELEM_W;
  localparam int CW     = $clog2(FRAME_MAX);
  localparam int LIFO_D = FRAME_MAX - 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_FILL   = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                m_valid_q, m_valid_d;
  logic [DATA_W-1:0]   m_data_q, m_data_d;
  logic                m_last_q, m_last_d;
  logic                ovf_q, ovf_d;
  logic [DATA_W-1:0]   lifo_q [LIFO_D];

  logic                s_ready_c;
  logic                push_en;
  logic                ovf_set;
  logic                out_beat;
  logic                out_free;
  logic [1:0]          eff_mode;

  function automatic logic [DATA_W-1:0] xform(input logic [1:0] md,
                                               input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = d;
    case (md)
      2'b01: for (int i = 0; i < DATA_W; i++) r[i] = d[DATA_W-1-i];
      2'b10: for (int k = 0; k < N_ELEM; k++)
               r[k*ELEM_W +: ELEM_W] = d[(N_ELEM-1-k)*ELEM_W +: ELEM_W];
      default: r = d;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    s_ready_c = 1'b0;
    push_en   = 1'b0;
    ovf_set   = 1'b0;
    out_beat  = m_valid_q & m_ready;
    out_free  = ~m_valid_q | m_ready;
    eff_mode  = (state_q == S_IDLE) ? mode : mode_q;

    if (out_beat) m_valid_d = 1'b0;

    case (state_q)
      S_IDLE, S_STREAM, S_FILL: begin
        // A new frame waits for the output register so FILL never shows m_valid.
        s_ready_c = (state_q == S_FILL) ? 1'b1 : out_free;
        if (s_valid && s_ready_c) begin
          if (state_q == S_IDLE) mode_d = mode;
          if (eff_mode == 2'b11) begin
            // The newest word bypasses the LIFO straight into the output register.
            if (s_last || cnt_q == CW'(FRAME_MAX - 1)) begin
              m_valid_d = 1'b1;
              m_data_d  = s_data;
              m_last_d  = (cnt_q == '0);
              ovf_set   = ~s_last;
              state_d   = S_DRAIN;
            end else begin
              push_en = 1'b1;
              cnt_d   = cnt_q + CW'(1);
              state_d = S_FILL;
            end
          end else begin
            m_valid_d = 1'b1;
            m_data_d  = xform(eff_mode, s_data);
            m_last_d  = s_last;
            state_d   = s_last ? S_IDLE : S_STREAM;
          end
        end
      end
      S_DRAIN: begin
        if (out_beat) begin
          if (cnt_q != '0) begin
            m_valid_d = 1'b1;
            m_data_d  = lifo_q[cnt_q - CW'(1)];
            m_last_d  = (cnt_q == CW'(1));
            cnt_d     = cnt_q - CW'(1);
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    ovf_d = ovf_set ? 1'b1 : (clr_err ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mode_q    <= 2'b00;
      cnt_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage only; occupancy lives in cnt_q, so reset needs no clearing here.
  always_ff @(posedge clk) begin
    if (push_en) lifo_q[cnt_q] <= s_data;
  end

  assign s_ready = rst_n & s_ready_c;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;
  assign busy    = (state_q != S_IDLE) | m_valid_q;
  assign ovf_err = ovf_q;

endmodule

// File: tb/tb_stream_reverse_unit.sv
// Bench for stream_reverse_unit: directed scenarios plus random frames checked
// against a queue-based reference of the three reversal rules.
module tb_stream_reverse_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [31:0] m_data;
  logic        m_last;
  logic        busy;
  logic        ovf_err;
  logic        clr_err = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rand_rdy = 1'b0;

  logic [31:0] stim_d[$];
  bit          stim_l[$];
  logic [1:0]  stim_m[$];
  logic [31:0] exp_d[$];
  bit          exp_l[$];
  bit          exp_ovf;
  logic [31:0] got_d[$];
  bit          got_l[$];
  int          got_t[$];

  stream_reverse_unit #(.DATA_W(32), .ELEM_W(8), .FRAME_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .ovf_err(ovf_err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1 m_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: collects accepted words and checks hold-while-stalled.
  initial begin
    bit prev_stall = 1'b0;
    logic [31:0] prev_d;
    bit prev_l;
    forever begin
      @(negedge clk);
      if (!rst_n) prev_stall = 1'b0;
      else begin
        if (prev_stall) begin
          checks++;
          if (m_valid !== 1'b1 || m_data !== prev_d || m_last !== prev_l) begin
            errors++;
            $display("FAIL stall_hold: got v=%0b %h/%0b, need v=1 %h/%0b",
                     m_valid, m_data, m_last, prev_d, prev_l);
          end
        end
        if (m_valid === 1'b1 && m_ready) begin
          got_d.push_back(m_data); got_l.push_back(m_last); got_t.push_back(cyc);
        end
        prev_stall = (m_valid === 1'b1) && !m_ready;
        prev_d = m_data; prev_l = m_last;
      end
    end
  end

  task automatic send_word(input logic [31:0] d, input bit l, input logic [1:0] md);
    int t = 0;
    s_valid = 1'b1; s_data = d; s_last = l; mode = md;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      t++;
      if (t > 300) begin
        checks++; errors++;
        $display("FAIL send_timeout: s_ready stayed %0b, need 1", s_ready);
        break;
      end
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  // Reference: frames split at s_last, mode taken from each frame's first word;
  // mode 3 reverses word order in chunks of at most 4, a full chunk without last overflows.
  task automatic model_run();
    logic [1:0] cur = 2'b00;
    bit first = 1'b1;
    logic [31:0] chunk[$];
    logic [31:0] t;
    exp_d.delete(); exp_l.delete(); exp_ovf = 1'b0;
    foreach (stim_d[i]) begin
      if (first) cur = stim_m[i];
      first = 1'b0;
      if (cur != 2'b11) begin
        if (cur == 2'b01) t = {<<{stim_d[i]}};
        else if (cur == 2'b10) t = {<<8{stim_d[i]}};
        else t = stim_d[i];
        exp_d.push_back(t); exp_l.push_back(stim_l[i]);
        if (stim_l[i]) first = 1'b1;
      end else begin
        chunk.push_back(stim_d[i]);
        if (stim_l[i] || chunk.size() == 4) begin
          if (!stim_l[i]) exp_ovf = 1'b1;
          while (chunk.size() > 0) begin
            exp_d.push_back(chunk.pop_back());
            exp_l.push_back(chunk.size() == 0);
          end
          first = 1'b1;
        end
      end
    end
  endtask

  task automatic clear_got();
    got_d.delete(); got_l.delete(); got_t.delete();
  endtask

  task automatic drive_all();
    foreach (stim_d[i]) send_word(stim_d[i], stim_l[i], stim_m[i]);
  endtask

  task automatic wait_out(input int n);
    int t = 0;
    while (got_d.size() < n && t < 1000) begin
      @(posedge clk); t++;
    end
    if (got_d.size() < n) begin
      checks++; errors++;
      $display("FAIL out_timeout: got %0d words, need %0d", got_d.size(), n);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic clear_err_pulse();
    @(posedge clk); #1 clr_err = 1'b1;
    @(posedge clk); #1 clr_err = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({s_ready, m_valid, m_last, busy, ovf_err} !== 5'b0 || m_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: got rdy=%0b v=%0b l=%0b busy=%0b ovf=%0b d=%h, need all 0",
               s_ready, m_valid, m_last, busy, ovf_err, m_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %0b need 1", s_ready);
    end
  endtask

  task automatic test_bit_rev();
    rand_rdy = 1'b0; clear_got();
    @(posedge clk); #1;
    send_word(32'h0000_0001, 1'b1, 2'b01);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 32'h8000_0000 || m_last !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL bit_rev_out: got v=%0b %h l=%0b busy=%0b, need 1 80000000 1 1",
               m_valid, m_data, m_last, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || m_valid !== 1'b0) begin
      errors++; $display("FAIL bit_rev_idle: got busy=%0b v=%0b, need 0 0", busy, m_valid);
    end
  endtask

  task automatic test_elem_rev();
    logic [31:0] e[2];
    e[0] = 32'h4433_2211; e[1] = 32'hD4C3_B2A1;
    rand_rdy = 1'b0; clear_got();
    send_word(32'h1122_3344, 1'b0, 2'b10);
    send_word(32'hA1B2_C3D4, 1'b1, 2'b10);
    wait_out(2);
    checks++;
    if (got_d.size() != 2) begin
      errors++; $display("FAIL elem_rev_count: got %0d need 2", got_d.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (got_d[i] !== e[i] || got_l[i] !== (i == 1)) begin
          errors++;
          $display("FAIL elem_rev_word%0d: got %h/%0b need %h/%0b", i, got_d[i], got_l[i], e[i], i == 1);
        end
      end
      checks++;
      if (got_t[1] - got_t[0] != 1) begin
        errors++; $display("FAIL elem_rev_rate: got gap %0d need 1", got_t[1] - got_t[0]);
      end
    end
  endtask

  task automatic test_frame_rev();
    stim_d.delete(); stim_l.delete(); stim_m.delete();
    for (int i = 0; i < 3; i++) begin
      stim_d.push_back($urandom); stim_l.push_back(i == 2); stim_m.push_back(2'b11);
    end
    model_run();
    rand_rdy = 1'b1; clear_got();
    drive_all();
    checks++;
    if (s_ready !== 1'b0) begin
      errors++; $display("FAIL frame_rev_ready_low: got %0b need 0", s_ready);
    end
    wait_out(exp_d.size());
    checks++;
    if (got_d.size() != exp_d.size()) begin
      errors++; $display("FAIL frame_rev_count: got %0d need %0d", got_d.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL frame_rev_word%0d: got %h/%0b need %h/%0b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_overflow();
    stim_d.delete(); stim_l.delete(); stim_m.delete();
    for (int i = 0; i < 5; i++) begin
      stim_d.push_back($urandom); stim_l.push_back(i == 4); stim_m.push_back(2'b11);
    end
    model_run();
    rand_rdy = 1'b0; clear_got();
    for (int i = 0; i < 4; i++) send_word(stim_d[i], stim_l[i], stim_m[i]);
    checks++;
    if (ovf_err !== exp_ovf) begin
      errors++; $display("FAIL ovf_set: got %0b need %0b", ovf_err, exp_ovf);
    end
    send_word(stim_d[4], stim_l[4], stim_m[4]);
    wait_out(exp_d.size());
    checks++;
    if (got_d.size() != exp_d.size()) begin
      errors++; $display("FAIL ovf_count: got %0d need %0d", got_d.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL ovf_word%0d: got %h/%0b need %h/%0b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
    checks++;
    if (ovf_err !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky: got %0b need 1", ovf_err);
    end
    clear_err_pulse();
    checks++;
    if (ovf_err !== 1'b0) begin
      errors++; $display("FAIL ovf_clear: got %0b need 0", ovf_err);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] m1[6];
    m1 = '{2'b01, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01};
    stim_d.delete(); stim_l.delete(); stim_m.delete();
    for (int i = 0; i < 6; i++) begin
      stim_d.push_back($urandom); stim_l.push_back(i == 2 || i == 5); stim_m.push_back(m1[i]);
    end
    model_run();
    rand_rdy = 1'b1; clear_got();
    drive_all();
    wait_out(exp_d.size());
    checks++;
    if (got_d.size() != exp_d.size()) begin
      errors++; $display("FAIL b2b_count: got %0d need %0d", got_d.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL b2b_word%0d: got %h/%0b need %h/%0b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_reset_in_drain();
    int t = 0;
    rand_rdy = 1'b0; clear_got();
    send_word(32'hAAAA_0001, 1'b0, 2'b11);
    send_word(32'hAAAA_0002, 1'b0, 2'b11);
    send_word(32'hAAAA_0003, 1'b1, 2'b11);
    while (got_d.size() < 2 && t < 100) begin
      @(posedge clk); #2; t++;
    end
    checks++;
    if (got_d.size() != 2) begin
      errors++; $display("FAIL drain_partial: got %0d words need 2", got_d.size());
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL drain_reset: got v=%0b busy=%0b need 0 0", m_valid, busy);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    stim_d.delete(); stim_l.delete(); stim_m.delete();
    for (int i = 0; i < 3; i++) begin
      stim_d.push_back($urandom); stim_l.push_back(i == 2); stim_m.push_back(2'b11);
    end
    model_run();
    clear_got();
    drive_all();
    wait_out(exp_d.size());
    checks++;
    if (got_d.size() != exp_d.size()) begin
      errors++; $display("FAIL post_reset_count: got %0d need %0d", got_d.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL post_reset_word%0d: got %h/%0b need %h/%0b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_random();
    int len;
    logic [1:0] md;
    stim_d.delete(); stim_l.delete(); stim_m.delete();
    for (int f = 0; f < 20; f++) begin
      len = $urandom_range(1, 6);
      md = 2'($urandom_range(0, 3));
      for (int i = 0; i < len; i++) begin
        stim_d.push_back($urandom);
        stim_l.push_back(i == len - 1);
        stim_m.push_back(i == 0 ? md : 2'($urandom_range(0, 3)));
      end
    end
    model_run();
    rand_rdy = 1'b1; clear_got();
    drive_all();
    wait_out(exp_d.size());
    checks++;
    if (got_d.size() != exp_d.size()) begin
      errors++; $display("FAIL rand_count: got %0d need %0d", got_d.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL rand_word%0d: got %h/%0b need %h/%0b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
    checks++;
    if (ovf_err !== exp_ovf || busy !== 1'b0) begin
      errors++;
      $display("FAIL rand_end_state: got ovf=%0b busy=%0b need ovf=%0b busy=0", ovf_err, busy, exp_ovf);
    end
    clear_err_pulse();
  endtask

  initial begin
    test_reset();
    test_bit_rev();
    test_elem_rev();
    test_frame_rev();
    test_overflow();
    test_back_to_back();
    test_reset_in_drain();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
